// File: rtl/cpu_seq_decoder.sv
// Instruction sequencer/decoder for the 8-bit CPU: handshaked fetch, decode, memory/ALU wait, execute.
// Every strobe and data output is registered and is high during the cycle its target state is occupied.
module cpu_seq_decoder #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 9,
  parameter int SRAM_AW     = 8,
  parameter int ALU_LAT     = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               sys_rst,
  output logic               fetch_req,
  input  logic               instr_valid,
  input  logic [7:0]         instr_byte,
  input  logic [DATA_W-1:0]  operand1,
  input  logic [DATA_W-1:0]  operand2,
  output logic               pc_adv,
  output logic [1:0]         instr_size,
  output logic               jmp_en,
  output logic [PC_W-1:0]    jmp_addr,
  input  logic [DATA_W-1:0]  reg_a,
  input  logic [DATA_W-1:0]  reg_b,
  input  logic [DATA_W-1:0]  reg_c,
  input  logic [DATA_W-1:0]  reg_d,
  input  logic [DATA_W-1:0]  reg_flags,
  output logic               reg_wr_en,
  output logic [1:0]         reg_wr_addr,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_rd_en,
  input  logic               sram_rd_valid,
  input  logic [DATA_W-1:0]  sram_rd_data,
  output logic               sram_wr_en,
  output logic [DATA_W-1:0]  sram_wr_data,
  output logic               alu_start,
  output logic [2:0]         alu_inst,
  output logic [DATA_W-1:0]  op_1,
  output logic [DATA_W-1:0]  op_2,
  input  logic [DATA_W-1:0]  res,
  output logic               halted,
  output logic               err
);

  localparam int CNT_MAX = (MEM_TIMEOUT > ALU_LAT) ? MEM_TIMEOUT : ALU_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ALU_LOAD     = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [3:0] OP_MOV_R = 4'h0, OP_MOV_I = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                         OP_NOP   = 4'h4, OP_JMP   = 4'h5, OP_JZ  = 4'h6, OP_HLT = 4'h7;

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT_INSTR, S_DECODE, S_MEM_RD, S_MEM_WAIT, S_ALU_WAIT, S_EXEC, S_HALT
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [7:0]        instr_q, instr_n;
  logic [DATA_W-1:0] opnd1_q, opnd1_n, opnd2_q, opnd2_n;
  logic [DATA_W-1:0] rd_val, rs_val;
  logic              unused_flags;

  logic               fetch_req_n, pc_adv_n, jmp_en_n, reg_wr_en_n, sram_rd_en_n, sram_wr_en_n;
  logic               alu_start_n, halted_n, err_n;
  logic [1:0]         instr_size_n, reg_wr_addr_n;
  logic [PC_W-1:0]    jmp_addr_n;
  logic [DATA_W-1:0]  reg_wr_data_n, sram_wr_data_n, op_1_n, op_2_n;
  logic [SRAM_AW-1:0] sram_addr_n;
  logic [2:0]         alu_inst_n;

  function automatic logic [DATA_W-1:0] reg_pick(input logic [1:0] sel,
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    case (sel)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return d;
    endcase
  endfunction

  assign rd_val       = reg_pick(instr_q[3:2], reg_a, reg_b, reg_c, reg_d);
  assign rs_val       = reg_pick(instr_q[1:0], reg_a, reg_b, reg_c, reg_d);
  assign unused_flags = ^reg_flags[DATA_W-1:1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_n        = state;
    cnt_n          = cnt;
    instr_n        = instr_q;
    opnd1_n        = opnd1_q;
    opnd2_n        = opnd2_q;
    fetch_req_n    = 1'b0;
    pc_adv_n       = 1'b0;
    jmp_en_n       = 1'b0;
    reg_wr_en_n    = 1'b0;
    sram_rd_en_n   = 1'b0;
    sram_wr_en_n   = 1'b0;
    alu_start_n    = 1'b0;
    halted_n       = halted;
    err_n          = err;
    instr_size_n   = instr_size;
    reg_wr_addr_n  = reg_wr_addr;
    jmp_addr_n     = jmp_addr;
    reg_wr_data_n  = reg_wr_data;
    sram_wr_data_n = sram_wr_data;
    op_1_n         = op_1;
    op_2_n         = op_2;
    sram_addr_n    = sram_addr;
    alu_inst_n     = alu_inst;

    case (state)
      // Straight out of reset fetch_req is still low, so FETCH spends one cycle raising it.
      S_FETCH: begin
        if (fetch_req) state_n = S_WAIT_INSTR;
        else           fetch_req_n = 1'b1;
      end
      S_WAIT_INSTR: begin
        if (instr_valid) begin
          instr_n = instr_byte;
          opnd1_n = operand1;
          opnd2_n = operand2;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = S_EXEC;
        case (instr_q[7:4])
          OP_MOV_R: begin
            reg_wr_en_n = 1'b1; reg_wr_addr_n = instr_q[3:2]; reg_wr_data_n = rs_val;
            pc_adv_n = 1'b1; instr_size_n = 2'd1;
          end
          OP_MOV_I: begin
            reg_wr_en_n = 1'b1; reg_wr_addr_n = instr_q[3:2]; reg_wr_data_n = opnd1_q;
            pc_adv_n = 1'b1; instr_size_n = 2'd2;
          end
          OP_LD: begin
            sram_addr_n = SRAM_AW'(opnd1_q); sram_rd_en_n = 1'b1;
            cnt_n = '0; state_n = S_MEM_RD;
          end
          OP_ST: begin
            sram_addr_n = SRAM_AW'(opnd1_q); sram_wr_data_n = rs_val; sram_wr_en_n = 1'b1;
            pc_adv_n = 1'b1; instr_size_n = 2'd2;
          end
          OP_NOP: begin
            pc_adv_n = 1'b1; instr_size_n = 2'd1;
          end
          OP_JMP: begin
            jmp_en_n = 1'b1; jmp_addr_n = PC_W'({opnd2_q, opnd1_q}); instr_size_n = 2'd3;
          end
          OP_JZ: begin
            instr_size_n = 2'd3;
            if (reg_flags[0]) begin
              jmp_en_n = 1'b1; jmp_addr_n = PC_W'({opnd2_q, opnd1_q});
            end else begin
              pc_adv_n = 1'b1;
            end
          end
          OP_HLT: begin
            halted_n = 1'b1; state_n = S_HALT;
          end
          default: begin
            alu_start_n = 1'b1; alu_inst_n = instr_q[6:4];
            op_1_n = rd_val; op_2_n = rs_val;
            cnt_n = ALU_LOAD; state_n = S_ALU_WAIT;
          end
        endcase
      end
      S_MEM_RD: begin
        cnt_n   = '0;
        state_n = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        // A valid arriving on the last allowed cycle still completes the load.
        if (sram_rd_valid) begin
          reg_wr_en_n = 1'b1; reg_wr_addr_n = instr_q[3:2]; reg_wr_data_n = sram_rd_data;
          pc_adv_n = 1'b1; instr_size_n = 2'd2;
          cnt_n = '0; state_n = S_EXEC;
        end else if (cnt == TIMEOUT_LAST) begin
          err_n = 1'b1; halted_n = 1'b1;
          cnt_n = '0; state_n = S_HALT;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_ALU_WAIT: begin
        if (cnt == CNT_ONE) begin
          reg_wr_en_n = 1'b1; reg_wr_addr_n = instr_q[3:2]; reg_wr_data_n = res;
          pc_adv_n = 1'b1; instr_size_n = 2'd1;
          cnt_n = '0; state_n = S_EXEC;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_EXEC: begin
        fetch_req_n = 1'b1;
        state_n     = S_FETCH;
      end
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state here is plain flops, so every one is cleared.
    if (!sys_rst) begin
      state        <= S_FETCH;
      cnt          <= '0;
      instr_q      <= '0;
      opnd1_q      <= '0;
      opnd2_q      <= '0;
      fetch_req    <= 1'b0;
      pc_adv       <= 1'b0;
      jmp_en       <= 1'b0;
      reg_wr_en    <= 1'b0;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      alu_start    <= 1'b0;
      halted       <= 1'b0;
      err          <= 1'b0;
      instr_size   <= 2'd1;
      reg_wr_addr  <= '0;
      jmp_addr     <= '0;
      reg_wr_data  <= '0;
      sram_wr_data <= '0;
      op_1         <= '0;
      op_2         <= '0;
      sram_addr    <= '0;
      alu_inst     <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      instr_q      <= instr_n;
      opnd1_q      <= opnd1_n;
      opnd2_q      <= opnd2_n;
      fetch_req    <= fetch_req_n;
      pc_adv       <= pc_adv_n;
      jmp_en       <= jmp_en_n;
      reg_wr_en    <= reg_wr_en_n;
      sram_rd_en   <= sram_rd_en_n;
      sram_wr_en   <= sram_wr_en_n;
      alu_start    <= alu_start_n;
      halted       <= halted_n;
      err          <= err_n;
      instr_size   <= instr_size_n;
      reg_wr_addr  <= reg_wr_addr_n;
      jmp_addr     <= jmp_addr_n;
      reg_wr_data  <= reg_wr_data_n;
      sram_wr_data <= sram_wr_data_n;
      op_1         <= op_1_n;
      op_2         <= op_2_n;
      sram_addr    <= sram_addr_n;
      alu_inst     <= alu_inst_n;
    end
  end

endmodule

// File: tb/tb_cpu_seq_decoder.sv
// Directed bench for cpu_seq_decoder: drives program RAM, SRAM, ALU and a register-file model,
// sampling outputs on the falling edge and comparing against hand-computed values.
module tb_cpu_seq_decoder;
  localparam int DATA_W = 8, PC_W = 9, SRAM_AW = 8, ALU_LAT = 3, MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst, fetch_req, instr_valid, pc_adv, jmp_en, reg_wr_en, sram_rd_en, sram_rd_valid;
  logic sram_wr_en, alu_start, halted, err;
  logic [7:0] instr_byte, operand1, operand2, reg_flags, reg_wr_data, sram_rd_data, sram_wr_data;
  logic [7:0] op_1, op_2, res, sram_addr, reg_a, reg_b, reg_c, reg_d;
  logic [1:0] instr_size, reg_wr_addr;
  logic [2:0] alu_inst;
  logic [PC_W-1:0] jmp_addr;
  logic [7:0] rf [4];

  assign reg_a = rf[0];
  assign reg_b = rf[1];
  assign reg_c = rf[2];
  assign reg_d = rf[3];

  cpu_seq_decoder #(.DATA_W(DATA_W), .PC_W(PC_W), .SRAM_AW(SRAM_AW), .ALU_LAT(ALU_LAT),
                    .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .sys_rst(sys_rst), .fetch_req(fetch_req), .instr_valid(instr_valid),
    .instr_byte(instr_byte), .operand1(operand1), .operand2(operand2), .pc_adv(pc_adv),
    .instr_size(instr_size), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .reg_a(reg_a), .reg_b(reg_b),
    .reg_c(reg_c), .reg_d(reg_d), .reg_flags(reg_flags), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .sram_addr(sram_addr),
    .sram_rd_en(sram_rd_en), .sram_rd_valid(sram_rd_valid), .sram_rd_data(sram_rd_data),
    .sram_wr_en(sram_wr_en), .sram_wr_data(sram_wr_data), .alu_start(alu_start),
    .alu_inst(alu_inst), .op_1(op_1), .op_2(op_2), .res(res), .halted(halted), .err(err)
  );

  int n_checks = 0, n_fail = 0;

  // Observations of one instruction, cycle indices relative to the fetch_req cycle (0).
  int len, halt_cyc, wr_n, wr_cyc, pc_n, jmp_n, rd_n, rd_cyc, sw_n, as_n, as_cyc;
  logic [1:0] wr_addr_s, pc_size_s;
  logic [7:0] wr_data_s, rd_addr_s, sw_addr_s, sw_data_s, op1_s, op2_s;
  logic [2:0] alu_inst_s;
  logic [PC_W-1:0] jmp_addr_s;
  logic err_s;

  task automatic do_reset();
    @(negedge clk); sys_rst = 1'b0;
    @(negedge clk); sys_rst = 1'b1;
    @(negedge clk);
  endtask

  // Serves one instruction starting from a fetch_req and records every strobe until the next fetch_req.
  task automatic run_instr(input logic [7:0] ib, input logic [7:0] o1, input logic [7:0] o2,
                           input int rd_lat, input logic [7:0] rd_val, input logic [7:0] alu_val);
    int rd_issue = -100;
    len = -1; halt_cyc = -1; wr_n = 0; wr_cyc = -1; pc_n = 0; jmp_n = 0; rd_n = 0; rd_cyc = -1;
    sw_n = 0; as_n = 0; as_cyc = -1; res = 8'h11;
    for (int w = 0; w < 10 && fetch_req !== 1'b1; w++) @(negedge clk);
    if (fetch_req !== 1'b1) return;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (reg_wr_en) begin
        wr_n++; wr_cyc = k; wr_addr_s = reg_wr_addr; wr_data_s = reg_wr_data;
        rf[reg_wr_addr] = reg_wr_data;
      end
      if (pc_adv)     begin pc_n++; pc_size_s = instr_size; end
      if (jmp_en)     begin jmp_n++; jmp_addr_s = jmp_addr; end
      if (sram_rd_en) begin rd_n++; rd_cyc = k; rd_issue = k; rd_addr_s = sram_addr; end
      if (sram_wr_en) begin sw_n++; sw_addr_s = sram_addr; sw_data_s = sram_wr_data; end
      if (alu_start)  begin
        as_n++; as_cyc = k; alu_inst_s = alu_inst; op1_s = op_1; op2_s = op_2; res = alu_val;
      end
      if (halted && halt_cyc < 0) halt_cyc = k;
      if (fetch_req) begin len = k; break; end
      instr_valid = (k == 1);
      if (k == 1) begin instr_byte = ib; operand1 = o1; operand2 = o2; end
      else begin instr_byte = 8'h70; operand1 = 8'hEE; operand2 = 8'hEE; end
      sram_rd_valid = (rd_lat > 0) && (k == rd_issue + rd_lat);
      sram_rd_data  = sram_rd_valid ? rd_val : 8'h99;
    end
    instr_valid = 1'b0; sram_rd_valid = 1'b0;
    err_s = err;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({fetch_req, pc_adv, jmp_en, reg_wr_en, sram_rd_en, sram_wr_en, alu_start, halted, err} !== 9'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0", {fetch_req, pc_adv, jmp_en, reg_wr_en,
                         sram_rd_en, sram_wr_en, alu_start, halted, err});
    end
    n_checks++;
    if ({instr_size, alu_inst, jmp_addr, sram_addr, reg_wr_data, op_1, op_2} !== {2'd1, 44'd0}) begin
      n_fail++; $display("FAIL reset_data: size=%0d inst=%0d jmp=%h addr=%h wd=%h op=%h/%h want size 1 rest 0",
                         instr_size, alu_inst, jmp_addr, sram_addr, reg_wr_data, op_1, op_2);
    end
    sys_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_fetch: got %b want 1", fetch_req); end
  endtask

  task automatic test_mov();
    run_instr(8'h14, 8'h5A, 8'h00, 0, 8'h00, 8'h00);   // MOV b,#0x5A
    n_checks++;
    if ({wr_n, wr_addr_s, wr_data_s} !== {32'd1, 2'd1, 8'h5A}) begin
      n_fail++; $display("FAIL mov_imm_write: got n=%0d addr=%0d data=%h want n=1 addr=1 data=5a", wr_n, wr_addr_s, wr_data_s);
    end
    n_checks++;
    if ({pc_n, pc_size_s, jmp_n, len} !== {32'd1, 2'd2, 32'd0, 32'd4}) begin
      n_fail++; $display("FAIL mov_imm_retire: got pc=%0d size=%0d jmp=%0d len=%0d want 1 2 0 4", pc_n, pc_size_s, jmp_n, len);
    end
    run_instr(8'h0D, 8'hEE, 8'hEE, 0, 8'h00, 8'h00);   // MOV d,b
    n_checks++;
    if ({wr_n, wr_addr_s, wr_data_s} !== {32'd1, 2'd3, 8'h5A}) begin
      n_fail++; $display("FAIL mov_reg_write: got n=%0d addr=%0d data=%h want n=1 addr=3 data=5a", wr_n, wr_addr_s, wr_data_s);
    end
    n_checks++;
    if ({pc_n, pc_size_s, len} !== {32'd1, 2'd1, 32'd4}) begin
      n_fail++; $display("FAIL mov_reg_retire: got pc=%0d size=%0d len=%0d want 1 1 4", pc_n, pc_size_s, len);
    end
  endtask

  task automatic test_load_store();
    run_instr(8'h28, 8'h10, 8'h00, 3, 8'hC3, 8'h00);   // LD c,[0x10], valid 3 cycles after rd_en
    n_checks++;
    if ({rd_n, rd_cyc, rd_addr_s} !== {32'd1, 32'd3, 8'h10}) begin
      n_fail++; $display("FAIL ld_read: got n=%0d cyc=%0d addr=%h want 1 3 10", rd_n, rd_cyc, rd_addr_s);
    end
    n_checks++;
    if ({wr_n, wr_addr_s, wr_data_s, wr_cyc} !== {32'd1, 2'd2, 8'hC3, 32'd7}) begin
      n_fail++; $display("FAIL ld_write: got n=%0d addr=%0d data=%h cyc=%0d want 1 2 c3 7", wr_n, wr_addr_s, wr_data_s, wr_cyc);
    end
    n_checks++;
    if ({pc_size_s, len} !== {2'd2, 32'd8}) begin
      n_fail++; $display("FAIL ld_timing: got size=%0d len=%0d want 2 8", pc_size_s, len);
    end
    run_instr(8'h32, 8'h33, 8'h00, 0, 8'h00, 8'h00);   // ST [0x33],c
    n_checks++;
    if ({sw_n, sw_addr_s, sw_data_s, wr_n} !== {32'd1, 8'h33, 8'hC3, 32'd0}) begin
      n_fail++; $display("FAIL st_write: got n=%0d addr=%h data=%h regwr=%0d want 1 33 c3 0", sw_n, sw_addr_s, sw_data_s, wr_n);
    end
    n_checks++;
    if ({pc_n, pc_size_s, len} !== {32'd1, 2'd2, 32'd4}) begin
      n_fail++; $display("FAIL st_retire: got pc=%0d size=%0d len=%0d want 1 2 4", pc_n, pc_size_s, len);
    end
  endtask

  task automatic test_alu();
    run_instr(8'h91, 8'hEE, 8'hEE, 0, 8'h00, 8'h7F);   // ALU op 1, Rd=a Rs=b
    n_checks++;
    if ({as_n, as_cyc, alu_inst_s, op1_s, op2_s} !== {32'd1, 32'd3, 3'd1, 8'h21, 8'h5A}) begin
      n_fail++; $display("FAIL alu_dispatch: got n=%0d cyc=%0d inst=%0d ops=%h/%h want 1 3 1 21/5a",
                         as_n, as_cyc, alu_inst_s, op1_s, op2_s);
    end
    n_checks++;
    if (wr_cyc - as_cyc !== ALU_LAT) begin
      n_fail++; $display("FAIL alu_latency: got %0d want %0d", wr_cyc - as_cyc, ALU_LAT);
    end
    n_checks++;
    if ({wr_n, wr_addr_s, wr_data_s, pc_size_s, len} !== {32'd1, 2'd0, 8'h7F, 2'd1, 32'd7}) begin
      n_fail++; $display("FAIL alu_write: got n=%0d addr=%0d data=%h size=%0d len=%0d want 1 0 7f 1 7",
                         wr_n, wr_addr_s, wr_data_s, pc_size_s, len);
    end
  endtask

  task automatic test_jump();
    reg_flags = 8'h01;
    run_instr(8'h60, 8'hA5, 8'h01, 0, 8'h00, 8'h00);   // JZ 0x1A5, zero set
    n_checks++;
    if ({jmp_n, jmp_addr_s, pc_n, len} !== {32'd1, 9'h1A5, 32'd0, 32'd4}) begin
      n_fail++; $display("FAIL jz_taken: got jmp=%0d addr=%h pc=%0d len=%0d want 1 1a5 0 4", jmp_n, jmp_addr_s, pc_n, len);
    end
    reg_flags = 8'hFE;
    run_instr(8'h60, 8'hA5, 8'h01, 0, 8'h00, 8'h00);   // JZ 0x1A5, zero clear
    n_checks++;
    if ({jmp_n, pc_n, pc_size_s, len} !== {32'd0, 32'd1, 2'd3, 32'd4}) begin
      n_fail++; $display("FAIL jz_not_taken: got jmp=%0d pc=%0d size=%0d len=%0d want 0 1 3 4", jmp_n, pc_n, pc_size_s, len);
    end
    run_instr(8'h50, 8'h34, 8'hFF, 0, 8'h00, 8'h00);   // JMP, target truncated to 9 bits
    n_checks++;
    if ({jmp_n, jmp_addr_s, pc_n} !== {32'd1, 9'h134, 32'd0}) begin
      n_fail++; $display("FAIL jmp_trunc: got jmp=%0d addr=%h pc=%0d want 1 134 0", jmp_n, jmp_addr_s, pc_n);
    end
    run_instr(8'h40, 8'hEE, 8'hEE, 0, 8'h00, 8'h00);   // NOP
    n_checks++;
    if ({pc_n, pc_size_s, wr_n, sw_n, len} !== {32'd1, 2'd1, 32'd0, 32'd0, 32'd4}) begin
      n_fail++; $display("FAIL nop: got pc=%0d size=%0d wr=%0d sw=%0d len=%0d want 1 1 0 0 4", pc_n, pc_size_s, wr_n, sw_n, len);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int w = 0; w < 10 && fetch_req !== 1'b1; w++) @(negedge clk);
    @(negedge clk); instr_valid = 1'b1; instr_byte = 8'h24; operand1 = 8'h20; operand2 = 8'h00;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sram_rd_en, sram_addr} !== {1'b1, 8'h20}) begin
      n_fail++; $display("FAIL midwait_read: got en=%b addr=%h want 1 20", sram_rd_en, sram_addr);
    end
    @(negedge clk); sys_rst = 1'b0; sram_rd_valid = 1'b1; sram_rd_data = 8'h77;
    @(negedge clk);
    n_checks++;
    if ({fetch_req, pc_adv, jmp_en, reg_wr_en, sram_rd_en, sram_wr_en, alu_start, halted, err} !== 9'b0) begin
      n_fail++; $display("FAIL midwait_strobes: got %b want 0", {fetch_req, pc_adv, jmp_en, reg_wr_en,
                         sram_rd_en, sram_wr_en, alu_start, halted, err});
    end
    n_checks++;
    if ({instr_size, alu_inst, jmp_addr, sram_addr, reg_wr_data, op_1, op_2} !== {2'd1, 44'd0}) begin
      n_fail++; $display("FAIL midwait_data: size=%0d inst=%0d jmp=%h addr=%h wd=%h op=%h/%h want size 1 rest 0",
                         instr_size, alu_inst, jmp_addr, sram_addr, reg_wr_data, op_1, op_2);
    end
    sys_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fetch_req, err, reg_wr_en} !== 3'b100) begin
      n_fail++; $display("FAIL midwait_refetch: got fetch/err/wr=%b want 100", {fetch_req, err, reg_wr_en});
    end
    sram_rd_valid = 1'b0;
    run_instr(8'h40, 8'hEE, 8'hEE, 0, 8'h00, 8'h00);
    n_checks++;
    if ({wr_n, pc_n, len} !== {32'd0, 32'd1, 32'd4}) begin
      n_fail++; $display("FAIL midwait_resume: got wr=%0d pc=%0d len=%0d want 0 1 4", wr_n, pc_n, len);
    end
  endtask

  task automatic test_timeout();
    run_instr(8'h20, 8'h05, 8'h00, 0, 8'h00, 8'h00);   // LD a,[0x05], never valid
    n_checks++;
    if (halt_cyc - (rd_cyc + 1) !== MEM_TIMEOUT) begin
      n_fail++; $display("FAIL timeout_cycle: got %0d want %0d", halt_cyc - (rd_cyc + 1), MEM_TIMEOUT);
    end
    n_checks++;
    if ({err_s, halted, wr_n, pc_n, len} !== {1'b1, 1'b1, 32'd0, 32'd0, -32'sd1}) begin
      n_fail++; $display("FAIL timeout_state: got err=%b halted=%b wr=%0d pc=%0d len=%0d want 1 1 0 0 -1",
                         err_s, halted, wr_n, pc_n, len);
    end
    do_reset();
    run_instr(8'h2C, 8'h06, 8'h00, MEM_TIMEOUT, 8'h4B, 8'h00);   // LD d, valid on last cycle
    n_checks++;
    if ({wr_n, wr_addr_s, wr_data_s, err_s, halt_cyc, len} !== {32'd1, 2'd3, 8'h4B, 1'b0, -32'sd1, 32'd20}) begin
      n_fail++; $display("FAIL timeout_last_valid: got n=%0d addr=%0d data=%h err=%b halt=%0d len=%0d want 1 3 4b 0 -1 20",
                         wr_n, wr_addr_s, wr_data_s, err_s, halt_cyc, len);
    end
  endtask

  task automatic test_halt();
    run_instr(8'h70, 8'h00, 8'h00, 0, 8'h00, 8'h00);   // HLT
    n_checks++;
    if ({halt_cyc, len, pc_n, wr_n, jmp_n, err_s} !== {32'd3, -32'sd1, 32'd0, 32'd0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL halt: got halt=%0d len=%0d pc=%0d wr=%0d jmp=%0d err=%b want 3 -1 0 0 0 0",
                         halt_cyc, len, pc_n, wr_n, jmp_n, err_s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b0; instr_valid = 1'b0; instr_byte = 8'h00; operand1 = 8'h00; operand2 = 8'h00;
    sram_rd_valid = 1'b0; sram_rd_data = 8'h00; res = 8'h00; reg_flags = 8'h00;
    rf[0] = 8'h21; rf[1] = 8'h34; rf[2] = 8'h00; rf[3] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_mov();
    test_load_store();
    test_alu();
    test_jump();
    test_reset_mid_wait();
    test_timeout();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
